// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC and sequences FETCH -> WAIT -> EXEC for each instruction.
// Defining PC_FETCH_INSTRET_EN adds the instret_o retired-instruction counter.

module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] next_pc_i,
   input  logic        commit_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic [31:0] pc_address_o,
   output logic        misalign_trap_o,
   output logic        timeout_err_o
`ifdef PC_FETCH_INSTRET_EN
   ,
   output logic [31:0] instret_o
`endif
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_TRAP  = 2'd3;

   // Last WAIT cycle index; an ack arriving on this cycle still wins over the timeout.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        misalign_q, misalign_d;
   logic        timeout_q, timeout_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case leaves a variable unassigned (no latches).
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      req_d      = req_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;
      timeout_d  = timeout_q;
      wait_cnt_d = wait_cnt_q;

      case (state_q)
         S_FETCH: begin
            req_d      = 1'b1;
            addr_d     = pc_q;
            wait_cnt_d = 8'd0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (imem_ack_i) begin
               instr_d = imem_rdata_i;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = S_EXEC;
            end else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               req_d     = 1'b0;
               state_d   = S_TRAP;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_EXEC: begin
            // stall overrides commit; a misaligned target traps without touching the PC.
            if (commit_i && !stall_i) begin
               valid_d = 1'b0;
               if (next_pc_i[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
                  state_d    = S_TRAP;
               end else begin
                  pc_d    = next_pc_i;
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         instr_q    <= 32'd0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
         timeout_q  <= timeout_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign imem_req_o      = req_q;
   assign imem_addr_o     = addr_q;
   assign instr_o         = instr_q;
   assign instr_valid_o   = valid_q;
   assign pc_address_o    = pc_q;
   assign misalign_trap_o = misalign_q;
   assign timeout_err_o   = timeout_q;

`ifdef PC_FETCH_INSTRET_EN
   logic        retire;
   logic [31:0] instret_q;

   assign retire = (state_q == S_EXEC) && commit_i && !stall_i && (next_pc_i[1:0] == 2'b00);

   always_ff @(posedge clk_i) begin
      if (rst_i)       instret_q <= 32'd0;
      else if (retire) instret_q <= instret_q + 32'd1;
   end

   assign instret_o = instret_q;
`else
   // Counter not built; the sequencer above is unchanged.
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (MAX_WAIT=4, RESET_PC=0).
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.

module tb_pc_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] next_pc;
   logic        commit;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc_address;
   logic        misalign_trap;
   logic        timeout_err;
`ifdef PC_FETCH_INSTRET_EN
   logic [31:0] instret;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .next_pc_i      (next_pc),
      .commit_i       (commit),
      .stall_i        (stall),
      .imem_req_o     (imem_req),
      .imem_addr_o    (imem_addr),
      .imem_ack_i     (imem_ack),
      .imem_rdata_i   (imem_rdata),
      .instr_o        (instr),
      .instr_valid_o  (instr_valid),
      .pc_address_o   (pc_address),
      .misalign_trap_o(misalign_trap),
      .timeout_err_o  (timeout_err)
`ifdef PC_FETCH_INSTRET_EN
      ,
      .instret_o      (instret)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // FETCH edge, then a WAIT edge with ack; leaves the DUT in EXEC.
   task automatic do_fetch(input logic [31:0] rdata);
      tick();
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      tick();
      imem_ack   = 1'b0;
   endtask

   task automatic do_commit(input logic [31:0] npc);
      commit  = 1'b1;
      next_pc = npc;
      tick();
      commit  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b exp 0", imem_req); end
      n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h exp 0", imem_addr); end
      n_tests++; if (pc_address !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h exp 0", pc_address); end
      n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h exp 0", instr); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
      n_tests++; if ({misalign_trap, timeout_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {misalign_trap, timeout_err}); end
   endtask

   task automatic test_free_run();
      logic [31:0] rd;
      for (int i = 0; i < 3; i++) begin
         rd = 32'h0000_0013 + (i << 20);
         tick();
         n_tests++; if ({imem_req, instr_valid} !== 2'b10) begin n_fail++; $display("FAIL run%0d_fetch_req_valid: got %b exp 10", i, {imem_req, instr_valid}); end
         n_tests++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL run%0d_addr: got %h exp %h", i, imem_addr, 32'(4 * i)); end
         imem_ack = 1'b1; imem_rdata = rd;
         tick();
         imem_ack = 1'b0;
         n_tests++; if ({imem_req, instr_valid} !== 2'b01) begin n_fail++; $display("FAIL run%0d_exec_req_valid: got %b exp 01", i, {imem_req, instr_valid}); end
         n_tests++; if (instr !== rd) begin n_fail++; $display("FAIL run%0d_instr: got %h exp %h", i, instr, rd); end
         do_commit(32'(4 * i + 4));
         n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL run%0d_valid_drop: got %b exp 0", i, instr_valid); end
         n_tests++; if (pc_address !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL run%0d_pc: got %h exp %h", i, pc_address, 32'(4 * i + 4)); end
      end
   endtask

   task automatic test_redirect();
      do_fetch(32'h0000_0033);
      do_commit(32'h0000_0010);
      do_fetch(32'h0000_0063);
      n_tests++; if (pc_address !== 32'h10) begin n_fail++; $display("FAIL redir_pc_before: got %h exp 10", pc_address); end
      do_commit(32'h0000_0040);
      n_tests++; if (pc_address !== 32'h40) begin n_fail++; $display("FAIL redir_pc: got %h exp 40", pc_address); end
      tick();
      n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL redir_fetch: got req=%b addr=%h exp req=1 addr=40", imem_req, imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'hABCD_0001;
      tick();
      imem_ack = 1'b0;
   endtask

   task automatic test_stall();
      stall = 1'b1; commit = 1'b1; next_pc = 32'h0000_0080;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (pc_address !== 32'h40) begin n_fail++; $display("FAIL stall%0d_pc: got %h exp 40", i, pc_address); end
         n_tests++; if ({instr_valid, instr} !== {1'b1, 32'hABCD_0001}) begin n_fail++; $display("FAIL stall%0d_instr: got v=%b %h exp v=1 abcd0001", i, instr_valid, instr); end
      end
      stall = 1'b0;
      tick();
      commit = 1'b0;
      n_tests++; if ({instr_valid, pc_address} !== {1'b0, 32'h80}) begin n_fail++; $display("FAIL stall_release: got v=%b pc=%h exp v=0 pc=80", instr_valid, pc_address); end
   endtask

   task automatic test_misalign();
      do_fetch(32'h0000_0013);
      do_commit(32'h0000_0102);
      n_tests++; if (misalign_trap !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b exp 1", misalign_trap); end
      n_tests++; if (pc_address !== 32'h80) begin n_fail++; $display("FAIL mis_pc: got %h exp 80", pc_address); end
      n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b exp 0", instr_valid); end
      imem_ack = 1'b1; commit = 1'b1; next_pc = 32'h0000_0200;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if ({imem_req, instr_valid, misalign_trap, pc_address} !== {3'b001, 32'h80}) begin n_fail++; $display("FAIL mis_hold%0d: got req=%b v=%b trap=%b pc=%h exp 0 0 1 80", i, imem_req, instr_valid, misalign_trap, pc_address); end
      end
      imem_ack = 1'b0; commit = 1'b0;
      do_reset();
      n_tests++; if ({misalign_trap, pc_address} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL mis_reset: got trap=%b pc=%h exp 0 0", misalign_trap, pc_address); end
      tick();
      n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL mis_restart: got req=%b addr=%h exp 1 0", imem_req, imem_addr); end
   endtask

   task automatic test_timeout();
      do_reset();
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if ({imem_req, timeout_err} !== 2'b10) begin n_fail++; $display("FAIL to_wait%0d: got req=%b err=%b exp 1 0", i, imem_req, timeout_err); end
      end
      tick();
      n_tests++; if ({imem_req, timeout_err} !== 2'b01) begin n_fail++; $display("FAIL to_expire: got req=%b err=%b exp 0 1", imem_req, timeout_err); end
      imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
      tick(); tick();
      imem_ack = 1'b0;
      n_tests++; if ({imem_req, instr_valid, timeout_err} !== 3'b001) begin n_fail++; $display("FAIL to_sticky: got req=%b v=%b err=%b exp 0 0 1", imem_req, instr_valid, timeout_err); end
   endtask

   task automatic test_ack_on_threshold();
      do_reset();
      tick();
      tick(); tick(); tick();
      imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
      tick();
      imem_ack = 1'b0;
      n_tests++; if ({instr_valid, timeout_err, imem_req} !== 3'b100) begin n_fail++; $display("FAIL thr_ack: got v=%b err=%b req=%b exp 1 0 0", instr_valid, timeout_err, imem_req); end
      n_tests++; if (instr !== 32'h5555_AAAA) begin n_fail++; $display("FAIL thr_instr: got %h exp 5555aaaa", instr); end
   endtask

   task automatic test_top_address();
      do_commit(32'hFFFF_FFFC);
      n_tests++; if ({misalign_trap, pc_address} !== {1'b0, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL top_pc: got trap=%b pc=%h exp 0 fffffffc", misalign_trap, pc_address); end
      tick();
      n_tests++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL top_addr: got %h exp fffffffc", imem_addr); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midwait_req: got %b exp 0", imem_req); end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      n_tests++; if ({imem_req, instr_valid, instr} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL midwait_late_ack: got req=%b v=%b instr=%h exp 1 0 0", imem_req, instr_valid, instr); end
   endtask

`ifdef PC_FETCH_INSTRET_EN
   task automatic test_instret();
      do_reset();
      n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL instret_reset: got %0d exp 0", instret); end
      for (int i = 0; i < 5; i++) begin
         do_fetch(32'h0000_0013);
         do_commit(32'(4 * i + 4));
      end
      do_fetch(32'h0000_0013);
      stall = 1'b1; commit = 1'b1; next_pc = 32'h0000_0018;
      tick();
      stall = 1'b0; commit = 1'b0;
      n_tests++; if (instret !== 32'd5) begin n_fail++; $display("FAIL instret_stall: got %0d exp 5", instret); end
      do_commit(32'h0000_0019);
      n_tests++; if ({misalign_trap, instret} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL instret_misalign: got trap=%b cnt=%0d exp 1 5", misalign_trap, instret); end
   endtask
`endif

   initial begin
      rst = 1'b0; next_pc = 32'h0; commit = 1'b0; stall = 1'b0;
      imem_ack = 1'b0; imem_rdata = 32'h0;
      test_reset();
      test_free_run();
      test_redirect();
      test_stall();
      test_misalign();
      test_timeout();
      test_ack_on_threshold();
      test_top_address();
      test_reset_mid_wait();
`ifdef PC_FETCH_INSTRET_EN
      test_instret();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencer that owns the architectural PC register and drives the instruction-fetch handshake for the core.
- Each instruction cycle runs fetch at pc_address, then wait for memory, then present the instruction and hold it until the execute stage commits.
- On commit it loads next_pc from the combinational next-PC unit, which resolves jal/jalr/branch/PC+4.
- Catches misaligned targets and fetch timeouts as sticky errors.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, WAIT-state cycles without imem_ack before timeout_err (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
next_pc  input  32  target from next-PC unit, valid while instr_valid=1
commit  input  1  current instruction completes this cycle; take next_pc
stall  input  1  hold current instruction; overrides commit
imem_req  output  1  fetch request (registered)
imem_addr  output  32  fetch address (registered)
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  32  fetched word, valid with imem_ack
instr  output  32  latched instruction
instr_valid  output  1  instr/pc_address valid for execute
pc_address  output  32  current PC, feeds next-PC unit
misalign_trap  output  1  sticky: committed next_pc[1:0]!=0
timeout_err  output  1  sticky: fetch exceeded MAX_WAIT

Behaviour:
- Reset: any cycle with rst=1 sets the following, regardless of the current state:
  - state=FETCH, pc_address=RESET_PC, imem_addr=RESET_PC
  - imem_req=0, instr=0, instr_valid=0, misalign_trap=0, timeout_err=0, wait_cnt=0
- States: FETCH, WAIT, EXEC, TRAP. All outputs are registered.
- FETCH (1 cycle):
  - imem_req<=1, imem_addr<=pc_address, wait_cnt<=0; next state WAIT.
- WAIT:
  - imem_req held 1; imem_addr stable.
  - If imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0; next state EXEC.
  - Else if wait_cnt==MAX_WAIT-1: timeout_err<=1, imem_req<=0; next state TRAP.
  - Else wait_cnt<=wait_cnt+1.
  - Ack on the threshold cycle: ack wins, no error.
- EXEC:
  - stall=1: hold everything, regardless of commit.
  - commit=1 and stall=0 with next_pc[1:0]!=0: misalign_trap<=1, instr_valid<=0, pc_address unchanged; next state TRAP.
  - commit=1 and stall=0 with next_pc aligned: pc_address<=next_pc, instr_valid<=0; next state FETCH.
  - Neither asserted: hold.
- TRAP:
  - imem_req=0, instr_valid=0; remain until rst. Error flags stay set.
- commit, stall and next_pc are ignored outside EXEC. imem_ack is ignored outside WAIT.
- Latency: with ack on the first WAIT cycle, instr_valid rises 2 cycles after entering FETCH. Minimum 3 cycles per instruction (FETCH, WAIT, EXEC with commit).
- PC arithmetic is 32-bit; no wrap check. next_pc=32'hFFFF_FFFC is legal.
- wait_cnt width is 8 bits.
- rst asserted mid-WAIT drops imem_req on the next edge; a late ack after reset is ignored because the state is FETCH.

Optional Feature:
Macro: PC_FETCH_INSTRET_EN
- Defined:
  - Adds output instret (32), a retired-instruction counter.
  - Reset value 0. Increments by 1 on each aligned commit in EXEC with stall=0.
  - Does not increment on a misaligned commit. Wraps 32'hFFFF_FFFF to 0.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
1. Reset then free-run: rst 1 cycle, ack on first WAIT cycle, imem_rdata=32'h00000013, commit with next_pc=pc+4 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses for 1 cycle each; 3 cycles per instruction.
2. Redirect: in EXEC at pc=0x10, next_pc=0x40, commit=1 -> next imem_addr=0x40, pc_address=0x40.
3. Stall vs commit: stall=1 and commit=1 for 3 cycles, then commit only -> pc held 3 cycles, then loads next_pc; instr unchanged during the stall.
4. Misaligned: commit with next_pc=0x102 -> misalign_trap=1, pc_address unchanged, imem_req stays 0 until rst; rst clears the flag and restarts at RESET_PC.
5. Timeout with MAX_WAIT=4:
   - no ack for 4 WAIT cycles -> timeout_err=1, imem_req=0;
   - repeat with ack on the 4th WAIT cycle -> no error, instr_valid=1.
6. With PC_FETCH_INSTRET_EN: 5 aligned commits, 1 stalled cycle, 1 misaligned commit -> instret=5.
